// File: rtl/subtractor4.sv
// Registered ripple-borrow subtractor: {BOUT, DIF} = A - B - BR_IN, one cycle of latency.
// BOUT of one instance may feed BR_IN of the next-higher slice when chaining.

module fsub_cell (
    input  logic a,
    input  logic b,
    input  logic br_in,
    output logic d,
    output logic br_out
);
    assign d      = a ^ b ^ br_in;
    assign br_out = (~a & b) | (~(a ^ b) & br_in);
endmodule

module subtractor4 #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BR_IN,
    input  logic             IN_VALID,
    output logic [WIDTH-1:0] DIF,
    output logic             BOUT,
    output logic             OUT_VALID
);
    localparam int STAGES = 1;

    typedef struct packed {
        logic             bout;
        logic [WIDTH-1:0] dif;
    } sub_rsp_t;

    logic [WIDTH:0]   br;
    logic [WIDTH-1:0] d;
    logic [STAGES:0]  vld_pipe;
    sub_rsp_t         rsp_q;

    // Borrow ripples LSB to MSB; the chain stays purely combinational.
    assign br[0] = BR_IN;

    fsub_cell u_cell [WIDTH-1:0] (
        .a      (A),
        .b      (B),
        .br_in  (br[WIDTH-1:0]),
        .d      (d),
        .br_out (br[WIDTH:1])
    );

    assign vld_pipe[0] = IN_VALID;

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_pipe[STAGES:1] <= '0;
            rsp_q              <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            // Data holds its last value while no valid input arrives.
            if (IN_VALID)
                rsp_q <= '{bout: br[WIDTH], dif: d};
        end
    end

    assign DIF       = rsp_q.dif;
    assign BOUT      = rsp_q.bout;
    assign OUT_VALID = vld_pipe[STAGES];
endmodule

// File: tb/tb_subtractor4.sv
// Directed and exhaustive checks of subtractor4 against hand values and an arithmetic model.
module tb_subtractor4;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] A = '0, B = '0;
    logic       BR_IN = 1'b0, IN_VALID = 1'b0;
    logic [3:0] DIF;
    logic       BOUT, OUT_VALID;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       bi;
        logic [3:0] dif;
        logic       bout;
    } vec_t;

    vec_t vecs [14];

    subtractor4 #(.WIDTH(4)) dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .BR_IN(BR_IN), .IN_VALID(IN_VALID),
        .DIF(DIF), .BOUT(BOUT), .OUT_VALID(OUT_VALID)
    );

    always #5 CLK = ~CLK;

    // Drive one cycle's inputs, then sample #1 after the capturing edge.
    task automatic drive(input logic r, input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic bi);
        RST = r; IN_VALID = v; A = a; B = b; BR_IN = bi;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] dif_e,
                       input logic bout_e, input logic ov_e);
        total++;
        if ({OUT_VALID, BOUT, DIF} !== {ov_e, bout_e, dif_e}) begin
            bad++;
            $display("FAIL %s: got dif=%0d bout=%b ov=%b, want dif=%0d bout=%b ov=%b",
                     nm, DIF, BOUT, OUT_VALID, dif_e, bout_e, ov_e);
        end
    endtask

    initial begin
        vecs = '{
            '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0},
            '{4'd3,  4'd0,  1'b0, 4'd3,  1'b0},
            '{4'd6,  4'd0,  1'b0, 4'd6,  1'b0},
            '{4'd9,  4'd0,  1'b0, 4'd9,  1'b0},
            '{4'd9,  4'd0,  1'b1, 4'd8,  1'b0},
            '{4'd9,  4'd5,  1'b1, 4'd3,  1'b0},
            '{4'd9,  4'd8,  1'b0, 4'd1,  1'b0},
            '{4'd9,  4'd9,  1'b0, 4'd0,  1'b0},
            '{4'd5,  4'd9,  1'b0, 4'd12, 1'b1},
            '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1},
            '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1},
            '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1},
            '{4'd15, 4'd0,  1'b0, 4'd15, 1'b0},
            '{4'd8,  4'd7,  1'b1, 4'd0,  1'b0}
        };

        // Reset with a valid-looking input present: it must be discarded.
        drive(1'b1, 1'b1, 4'd9, 4'd5, 1'b1);
        chk("reset_c0", 4'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'd9, 4'd5, 1'b1);
        chk("reset_c1", 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'd9, 4'd5, 1'b1);
        chk("reset_first", 4'd3, 1'b0, 1'b1);

        // Directed sweep and borrow edges, back-to-back.
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].bi);
            chk($sformatf("vec%0d_%0d-%0d-%0d", i, vecs[i].a, vecs[i].b, vecs[i].bi),
                vecs[i].dif, vecs[i].bout, 1'b1);
        end

        // Exhaustive against integer arithmetic.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bi = 0; bi < 2; bi++) begin
                    int diff;
                    logic [3:0] de;
                    diff = a - b - bi;
                    de   = 4'(diff & 15);
                    drive(1'b0, 1'b1, 4'(a), 4'(b), 1'(bi));
                    chk($sformatf("exh_%0d-%0d-%0d", a, b, bi), de, diff < 0, 1'b1);
                end

        // Hold while invalid, inputs wandering.
        drive(1'b0, 1'b1, 4'd9, 4'd5, 1'b1);
        chk("hold_cap", 4'd3, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)),
                  1'($urandom_range(1)));
            chk($sformatf("hold%0d", k), 4'd3, 1'b0, 1'b0);
        end

        // Mid-stream reset drops the vector presented during reset.
        drive(1'b0, 1'b1, 4'd2, 4'd1, 1'b0);
        chk("mid_pre", 4'd1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'd7, 4'd2, 1'b0);
        chk("mid_rst", 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'd4, 4'd6, 1'b1);
        chk("mid_resume", 4'd13, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 4'd12, 4'd3, 1'b0);
        chk("mid_resume2", 4'd9, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 4'd7, 4'd2, 1'b0);
        chk("mid_idle", 4'd9, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
